// File: rtl/pipe_repeater_pkg.sv
// pipe_repeater_pkg
//   Shared definitions for the pipe_repeater block.
//   occ_width(length): bit width of an occupancy count that can hold 0..2*length.
package pipe_repeater_pkg;

    function automatic int unsigned occ_width(input int unsigned length);
        return $clog2(2 * length + 1);
    endfunction

endpackage

// File: rtl/pipe_repeater_stage.sv
// pipe_repeater_stage
//   One skid-buffered register slice. Data, valid and ready are all registered at
//   the slice boundary, so chaining slices never builds a long combinational path.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     s_data/s_valid    upstream word and its valid
//     s_ready           upstream may transfer (registered: skid register is empty)
//     m_data/m_valid    downstream word and its valid (the main register)
//     m_ready           downstream accepts the main register this cycle
module pipe_repeater_stage #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    (* dont_touch = "true" *) logic             main_valid_q;
    (* dont_touch = "true" *) logic [WIDTH-1:0] main_data_q;
    (* dont_touch = "true" *) logic             skid_valid_q;
    (* dont_touch = "true" *) logic [WIDTH-1:0] skid_data_q;

    logic             main_valid_d;
    logic [WIDTH-1:0] main_data_d;
    logic             skid_valid_d;
    logic [WIDTH-1:0] skid_data_d;

    logic in_fire;
    logic out_fire;

    assign in_fire  = s_valid & ~skid_valid_q;
    assign out_fire = main_valid_q & m_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_fire) begin
            if (skid_valid_q) begin
                // Skid refills main. No input can land here: ready was low this cycle.
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = in_fire;
                if (in_fire) begin
                    main_data_d = s_data;
                end
            end
        end else if (!main_valid_q) begin
            if (in_fire) begin
                main_valid_d = 1'b1;
                main_data_d  = s_data;
            end
        end else if (in_fire) begin
            // Main is stalled; park the word that arrived under a still-high ready.
            skid_valid_d = 1'b1;
            skid_data_d  = s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign s_ready = ~skid_valid_q;
    assign m_valid = main_valid_q;
    assign m_data  = main_data_q;

endmodule

// File: rtl/pipe_repeater.sv
// pipe_repeater
//   Registered valid/ready repeater: LENGTH skid slices in series, holding up to
//   2*LENGTH words, full throughput, strict FIFO order.
//   Ports:
//     clk, rst                       clock, synchronous active-high reset
//     in_data/in_valid/in_ready      upstream stream (in_ready is registered)
//     out_data/out_valid/out_ready   downstream stream (out_* are registered)
//     occupancy                      words held; only with PIPE_REPEATER_OCCUPANCY_EN
//   Build option: define PIPE_REPEATER_OCCUPANCY_EN to add the occupancy counter/port.
module pipe_repeater
    import pipe_repeater_pkg::*;
#(
    parameter int unsigned LENGTH = 1,
    parameter int unsigned WIDTH  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready
`ifdef PIPE_REPEATER_OCCUPANCY_EN
    ,
    output logic [occ_width(LENGTH)-1:0] occupancy
`endif
);

    // Element k is the input of stage k; element LENGTH is the block output.
    logic [LENGTH:0][WIDTH-1:0] chain_data;
    logic [LENGTH:0]            chain_valid;
    logic [LENGTH:0]            chain_ready;

    assign chain_data[0]       = in_data;
    assign chain_valid[0]      = in_valid;
    assign chain_ready[LENGTH] = out_ready;

    for (genvar k = 0; k < LENGTH; k++) begin : g_stage
        pipe_repeater_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .s_data  (chain_data[k]),
            .s_valid (chain_valid[k]),
            .s_ready (chain_ready[k]),
            .m_data  (chain_data[k+1]),
            .m_valid (chain_valid[k+1]),
            .m_ready (chain_ready[k+1])
        );
    end

    // Masking with rst keeps both handshakes dead during the reset cycle, even
    // though the slice registers only clear at its closing edge.
    assign in_ready  = chain_ready[0] & ~rst;
    assign out_valid = chain_valid[LENGTH] & ~rst;
    assign out_data  = chain_data[LENGTH];

`ifdef PIPE_REPEATER_OCCUPANCY_EN
    localparam int unsigned OccW = occ_width(LENGTH);

    logic [OccW-1:0] occ_q;
    logic [OccW-1:0] occ_d;
    logic            in_fire;
    logic            out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        occ_d = occ_q;
        unique case ({in_fire, out_fire})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipe_repeater.sv
// tb_pipe_repeater
//   Directed bench for pipe_repeater. Two instances: index 0 has LENGTH=3,
//   index 1 has LENGTH=2, both WIDTH=8. One cycle-stepping task drives a chosen
//   instance and keeps a FIFO scoreboard of accepted words with acceptance cycle.
//   Occupancy checks are compiled in only with PIPE_REPEATER_OCCUPANCY_EN.
module tb_pipe_repeater;
    import pipe_repeater_pkg::*;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst;
    logic [1:0][W-1:0] in_data;
    logic [1:0]        in_valid;
    logic [1:0]        in_ready;
    logic [1:0][W-1:0] out_data;
    logic [1:0]        out_valid;
    logic [1:0]        out_ready;
`ifdef PIPE_REPEATER_OCCUPANCY_EN
    logic [occ_width(3)-1:0] occ0;
    logic [occ_width(2)-1:0] occ1;
`endif

    pipe_repeater #(
        .LENGTH (3),
        .WIDTH  (W)
    ) u_l3 (
        .clk       (clk),
        .rst       (rst[0]),
        .in_data   (in_data[0]),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .out_data  (out_data[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0])
`ifdef PIPE_REPEATER_OCCUPANCY_EN
        ,
        .occupancy (occ0)
`endif
    );

    pipe_repeater #(
        .LENGTH (2),
        .WIDTH  (W)
    ) u_l2 (
        .clk       (clk),
        .rst       (rst[1]),
        .in_data   (in_data[1]),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .out_data  (out_data[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1])
`ifdef PIPE_REPEATER_OCCUPANCY_EN
        ,
        .occupancy (occ1)
`endif
    );

    typedef struct {
        logic [W-1:0] data;
        int           acc;
    } sb_t;

    typedef struct {
        bit           rst;
        bit           iv;
        logic [W-1:0] id;
        bit           ordy;
        bit           e_ir;
        bit           e_ov;
        logic [W-1:0] e_od;
    } vec_t;

    sb_t          sb[$];
    vec_t         tbl[9];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    bit           ir, ov, fired_out;
    logic [W-1:0] od;
    int           lat;
    bit           prev_hold = 1'b0;
    logic [W-1:0] prev_od = '0;
    int           prev_d = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle on instance d: drive at negedge, sample 2 time units later.
    task automatic step(input int d, input bit r, input bit v, input logic [W-1:0] dat,
                        input bit ordy);
        sb_t e;
        @(negedge clk);
        rst[d]       = r;
        in_valid[d]  = v;
        in_data[d]   = dat;
        out_ready[d] = ordy;
        #2;
        ir        = in_ready[d];
        ov        = out_valid[d];
        od        = out_data[d];
        fired_out = 1'b0;
`ifdef PIPE_REPEATER_OCCUPANCY_EN
        if (d == 0) check("occupancy", 32'(occ0), sb.size());
        else        check("occupancy", 32'(occ1), sb.size());
`endif
        if (prev_d == d && prev_hold && !r) begin
            check("hold_valid", 32'(ov), 1);
            check("hold_data", 32'(od), 32'(prev_od));
        end
        prev_d    = d;
        prev_hold = ov & ~ordy;
        prev_od   = od;
        if (r) begin
            sb.delete();
        end else begin
            if (ov && ordy) begin
                fired_out = 1'b1;
                if (sb.size() == 0) begin
                    check("output_without_input", 32'(ov), 0);
                end else begin
                    e   = sb.pop_front();
                    lat = cyc - e.acc;
                    check("out_data_order", 32'(od), 32'(e.data));
                end
            end
            if (v && ir) sb.push_back('{dat, cyc});
        end
        cyc++;
    endtask

    task automatic drain(input int d, input string name);
        for (int k = 0; k < 20 && sb.size() > 0; k++) step(d, 1'b0, 1'b0, '0, 1'b1);
        check(name, sb.size(), 0);
    endtask

    initial begin
        int           accepted;
        int           outs;
        bit           seen_ready;
        logic [W-1:0] nxt;

        rst       = 2'b11;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '0;

        //            rst iv  id     ordy ir  ov  od
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h22};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h22};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};

        // Reset state.
        step(0, 1'b1, 1'b0, '0, 1'b0);
        step(0, 1'b1, 1'b0, '0, 1'b0);
        check("reset_in_ready_low", 32'(ir), 0);
        step(0, 1'b0, 1'b0, '0, 1'b0);
        check("reset_out_valid", 32'(ov), 0);
        check("reset_out_data", 32'(od), 0);
        check("reset_in_ready", 32'(ir), 1);
`ifdef PIPE_REPEATER_OCCUPANCY_EN
        check("reset_occupancy", 32'(occ0), 0);
`endif

        // Table-driven vectors on LENGTH=3.
        for (int i = 0; i < 9; i++) begin
            step(0, tbl[i].rst, tbl[i].iv, tbl[i].id, tbl[i].ordy);
            check("tbl_in_ready", 32'(ir), 32'(tbl[i].e_ir));
            check("tbl_out_valid", 32'(ov), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) check("tbl_out_data", 32'(od), 32'(tbl[i].e_od));
        end

        // Latency and throughput: 0x01..0x10 back-to-back, LENGTH=3.
        step(0, 1'b1, 1'b0, '0, 1'b1);
        outs = 0;
        for (int i = 1; i <= 16; i++) begin
            step(0, 1'b0, 1'b1, 8'(i), 1'b1);
            check("stream_in_ready", 32'(ir), 1);
            if (fired_out) begin
                outs++;
                check("stream_latency", lat, 3);
            end
        end
        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            step(0, 1'b0, 1'b0, '0, 1'b1);
            if (fired_out) begin
                outs++;
                check("stream_latency", lat, 3);
            end
        end
        check("stream_count", outs, 16);

        // Full stall on LENGTH=2: exactly four words fit.
        step(1, 1'b1, 1'b0, '0, 1'b0);
        nxt      = 8'h40;
        accepted = 0;
        for (int k = 0; k < 8; k++) begin
            step(1, 1'b0, 1'b1, nxt, 1'b0);
            if (ir) begin
                accepted++;
                nxt++;
            end
        end
        check("stall_accepted", accepted, 4);
        check("stall_in_ready", 32'(ir), 0);
`ifdef PIPE_REPEATER_OCCUPANCY_EN
        check("stall_occupancy", 32'(occ1), 4);
`endif
        seen_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step(1, 1'b0, 1'b1, nxt, 1'b1);
            if (seen_ready) check("release_no_bubble", 32'(ir), 1);
            if (ir) begin
                seen_ready = 1'b1;
                nxt++;
            end
        end
        check("release_ready_seen", 32'(seen_ready), 1);
        drain(1, "stall_drain_empty");

        // Random valid/ready on LENGTH=3.
        step(0, 1'b1, 1'b0, '0, 1'b0);
        nxt = 8'h00;
        for (int k = 0; k < 400; k++) begin
            step(0, 1'b0, ($urandom_range(1, 100) <= 50), nxt,
                 ($urandom_range(1, 100) <= 30));
            if (in_valid[0] && ir) nxt++;
        end
        drain(0, "random_drain_empty");

        // Reset mid-stream: five words held, then a one-cycle reset.
        step(0, 1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(0, 1'b0, 1'b1, 8'(8'h60 + k), 1'b0);
            check("fill_in_ready", 32'(ir), 1);
        end
        step(0, 1'b1, 1'b0, '0, 1'b1);
        check("midrst_out_valid_in_reset", 32'(ov), 0);
        check("midrst_in_ready_in_reset", 32'(ir), 0);
        step(0, 1'b0, 1'b0, '0, 1'b1);
        check("midrst_out_valid_after", 32'(ov), 0);
`ifdef PIPE_REPEATER_OCCUPANCY_EN
        check("midrst_occupancy", 32'(occ0), 0);
`endif
        step(0, 1'b0, 1'b1, 8'hA5, 1'b1);
        outs = 0;
        for (int k = 0; k < 10 && outs == 0; k++) begin
            step(0, 1'b0, 1'b0, '0, 1'b1);
            if (fired_out) begin
                outs++;
                check("midrst_first_data", 32'(od), 32'hA5);
                check("midrst_latency", lat, 3);
            end
        end
        check("midrst_output_seen", outs, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
